// File: rtl/calendar_date_ctrl.sv
// -----------------------------------------------------------------------------
// calendar_date_ctrl
// Holds the current calendar day and month. The date advances on a one-per-day
// tick, or on set-mode button increments. A three-state sequencer shares one
// external binary-to-BCD splitter between the day and the month. It latches
// both BCD results for the seven-segment driver.
//
// Optional feature macro: CAL_LEAP_EN
//   defined   : adds a 2-bit year-mod-4 counter. February has 29 days when
//               the counter is 0.
//   undefined : February always has 28 days.
//
// Ports
//   i_clk, i_rst    clock and synchronous active-high reset
//   i_day_tick      pulse: advance the date by one day (ignored while i_set_en)
//   i_set_en        set mode enable
//   i_set_sel       set-mode field select (0 = day, 1 = month)
//   i_inc_btn       pulse: increment the selected field (only while i_set_en)
//   o_dd_out        binary value presented to the splitter
//   i_dd_msb_in     splitter tens digit (combinational from o_dd_out)
//   i_dd_lsb_in     splitter ones digit (combinational from o_dd_out)
//   o_day_bcd       {tens, ones} of the day
//   o_month_bcd     {tens, ones} of the month
//   o_bcd_valid     one-cycle pulse: both BCD outputs are coherent and updated
//   o_busy          a conversion pass is in progress
// -----------------------------------------------------------------------------
module calendar_date_ctrl #(
  parameter logic [4:0] DEFAULT_DAY   = 5'd1,
  parameter logic [3:0] DEFAULT_MONTH = 4'd1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_day_tick,
  input  logic       i_set_en,
  input  logic       i_set_sel,
  input  logic       i_inc_btn,
  output logic [4:0] o_dd_out,
  input  logic [3:0] i_dd_msb_in,
  input  logic [3:0] i_dd_lsb_in,
  output logic [7:0] o_day_bcd,
  output logic [7:0] o_month_bcd,
  output logic       o_bcd_valid,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONV_DAY = 2'd1,
    ST_CONV_MON = 2'd2
  } state_t;

  // Returns the last day of a month. The leap flag only affects February.
  function automatic logic [4:0] last_day(input logic [3:0] month, input logic leap);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: last_day = 5'd30;
      4'd2:                    last_day = leap ? 5'd29 : 5'd28;
      default:                 last_day = 5'd31;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_day;
  logic [3:0] r_month;
  logic       r_dirty;
  logic [4:0] r_dd_out;
  logic [7:0] r_day_bcd;
  logic [7:0] r_month_bcd;
  logic       r_bcd_valid;
  logic       r_busy;

  logic [4:0] w_day_nxt;
  logic [3:0] w_month_nxt;
  logic [3:0] w_month_inc;
  logic [4:0] w_last_cur;
  logic [4:0] w_last_new;
  logic       w_leap;
  logic       w_change;
  logic       w_latch_day;
  logic       w_latch_mon;
  logic       w_clear_dirty;

`ifdef CAL_LEAP_EN
  logic [1:0] r_year_mod4;
  logic       w_year_roll;

  assign w_leap      = (r_year_mod4 == 2'd0);
  // Only the Dec 31 -> Jan 1 day tick rolls the year. Set mode never touches it.
  assign w_year_roll = ~i_set_en & i_day_tick & (r_day >= w_last_cur) & (r_month == 4'd12);

  // Year-mod-4 counter for the February length.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_year_mod4 <= 2'd0;
    end else if (w_year_roll) begin
      r_year_mod4 <= r_year_mod4 + 2'd1;
    end
  end
`else
  assign w_leap = 1'b0;
`endif

  assign w_month_inc = (r_month == 4'd12) ? 4'd1 : (r_month + 4'd1);
  assign w_last_cur  = last_day(r_month, w_leap);
  assign w_last_new  = last_day(w_month_inc, w_leap);
  // set_en selects the event source. The other source is dropped.
  assign w_change    = i_set_en ? i_inc_btn : i_day_tick;

  // Next date from the tick or the set-mode increment.
  always_comb begin
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    if (i_set_en) begin
      if (i_inc_btn) begin
        if (i_set_sel) begin
          w_month_nxt = w_month_inc;
          // Clamp the day on the same edge, so an illegal date is never stored.
          if (r_day > w_last_new) begin
            w_day_nxt = w_last_new;
          end else begin
            w_day_nxt = r_day;
          end
        end else if (r_day >= w_last_cur) begin
          w_day_nxt = 5'd1;
        end else begin
          w_day_nxt = r_day + 5'd1;
        end
      end else begin
        w_day_nxt = r_day;
      end
    end else if (i_day_tick) begin
      if (r_day >= w_last_cur) begin
        w_day_nxt   = 5'd1;
        w_month_nxt = w_month_inc;
      end else begin
        w_day_nxt = r_day + 5'd1;
      end
    end else begin
      w_day_nxt = r_day;
    end
  end

  // Date registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_day   <= DEFAULT_DAY;
      r_month <= DEFAULT_MONTH;
    end else begin
      r_day   <= w_day_nxt;
      r_month <= w_month_nxt;
    end
  end

  // Dirty flag. A new change wins over the clear on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dirty <= 1'b1;
    end else if (w_change) begin
      r_dirty <= 1'b1;
    end else if (w_clear_dirty) begin
      r_dirty <= 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_dirty) begin
          w_state_nxt = ST_CONV_DAY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CONV_DAY: w_state_nxt = ST_CONV_MON;
      ST_CONV_MON: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer output decode.
  always_comb begin
    w_latch_day   = 1'b0;
    w_latch_mon   = 1'b0;
    w_clear_dirty = 1'b0;
    case (r_state)
      ST_IDLE:     w_clear_dirty = r_dirty;
      ST_CONV_DAY: w_latch_day   = 1'b1;
      ST_CONV_MON: w_latch_mon   = 1'b1;
      default: begin
        w_latch_day   = 1'b0;
        w_latch_mon   = 1'b0;
        w_clear_dirty = 1'b0;
      end
    endcase
  end

  // Splitter operand and latched BCD results. The operand is loaded on the
  // edge that enters each conversion state. It uses the post-edge date value,
  // so a change on that same edge is converted in the same pass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dd_out    <= 5'd0;
      r_day_bcd   <= 8'd0;
      r_month_bcd <= 8'd0;
      r_bcd_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_state_nxt == ST_CONV_DAY) begin
        r_dd_out <= w_day_nxt;
      end else if (w_state_nxt == ST_CONV_MON) begin
        r_dd_out <= {1'b0, w_month_nxt};
      end
      if (w_latch_day) begin
        r_day_bcd <= {i_dd_msb_in, i_dd_lsb_in};
      end
      if (w_latch_mon) begin
        r_month_bcd <= {i_dd_msb_in, i_dd_lsb_in};
      end
      r_bcd_valid <= w_latch_mon;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_dd_out    = r_dd_out;
  assign o_day_bcd   = r_day_bcd;
  assign o_month_bcd = r_month_bcd;
  assign o_bcd_valid = r_bcd_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_calendar_date_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_ctrl
// Scoreboard bench for calendar_date_ctrl. Each directed operation pushes its
// hand-computed {day_bcd, month_bcd} pair. A monitor pops and compares the pair
// on every bcd_valid pulse. The splitter is modelled with an ideal divide by 10.
// -----------------------------------------------------------------------------
module tb_calendar_date_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       day_tick;
  logic       set_en;
  logic       set_sel;
  logic       inc_btn;
  logic [4:0] dd_out;
  logic [3:0] dd_msb_in;
  logic [3:0] dd_lsb_in;
  logic [7:0] day_bcd;
  logic [7:0] month_bcd;
  logic       bcd_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign dd_msb_in = 4'(dd_out / 5'd10);
  assign dd_lsb_in = 4'(dd_out % 5'd10);

  calendar_date_ctrl #(.DEFAULT_DAY(5'd1), .DEFAULT_MONTH(4'd1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_day_tick  (day_tick),
    .i_set_en    (set_en),
    .i_set_sel   (set_sel),
    .i_inc_btn   (inc_btn),
    .o_dd_out    (dd_out),
    .i_dd_msb_in (dd_msb_in),
    .i_dd_lsb_in (dd_lsb_in),
    .o_day_bcd   (day_bcd),
    .o_month_bcd (month_bcd),
    .o_bcd_valid (bcd_valid),
    .o_busy      (busy)
  );

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every bcd_valid pulse must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst === 1'b0 && bcd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got %h%h expected no pulse", day_bcd, month_bcd);
      end else begin
        check("bcd_pair", {day_bcd, month_bcd}, exp_q.pop_front());
      end
    end
  end

  task automatic pulse(input logic tick, input logic inc);
    @(negedge clk);
    day_tick = tick;
    inc_btn  = inc;
    @(negedge clk);
    day_tick = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic op(input logic tick, input logic inc, input logic [15:0] exp);
    exp_q.push_back(exp);
    pulse(tick, inc);
    repeat (7) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; day_tick = 1'b0; set_en = 1'b0; set_sel = 1'b0; inc_btn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_day_bcd",   {8'h00, day_bcd},   16'h0000);
    check("rst_month_bcd", {8'h00, month_bcd}, 16'h0000);
    check("rst_dd_out",    {11'h000, dd_out},  16'h0000);
    check("rst_valid",     {15'h0000, bcd_valid}, 16'h0000);
    check("rst_busy",      {15'h0000, busy},   16'h0000);

    // Release: pass starts at the 1st edge, and bcd_valid follows the 3rd edge.
    exp_q.push_back({8'h01, 8'h01});
    rst = 1'b0;
    @(posedge clk); #1;
    check("busy_after_edge1", {15'h0000, busy}, 16'h0001);
    @(posedge clk); #1;
    check("no_valid_edge2", {15'h0000, bcd_valid}, 16'h0000);
    @(posedge clk); #1;
    check("valid_after_edge3", {15'h0000, bcd_valid}, 16'h0001);
    @(posedge clk); #1;
    check("busy_low_after", {14'h0000, busy, bcd_valid}, 16'h0000);
    repeat (4) @(negedge clk);

    // Set mode: advance the day to Jan 31.
    set_en = 1'b1; set_sel = 1'b0;
    for (int d = 2; d <= 31; d++) op(1'b0, 1'b1, {bcd(d), 8'h01});
    set_en = 1'b0;
    op(1'b1, 1'b0, {8'h01, 8'h02});                 // Jan 31 -> Feb 1

    set_en = 1'b1;
    for (int d = 2; d <= 28; d++) op(1'b0, 1'b1, {bcd(d), 8'h02});
    set_en = 1'b0;
`ifdef CAL_LEAP_EN
    op(1'b1, 1'b0, {8'h29, 8'h02});                 // year 0 is a leap year
    op(1'b1, 1'b0, {8'h01, 8'h03});
`else
    op(1'b1, 1'b0, {8'h01, 8'h03});                 // Feb 28 -> Mar 1
`endif

    // Mar 31, then a month increment clamps the day to Apr 30.
    set_en = 1'b1; set_sel = 1'b0;
    for (int d = 2; d <= 31; d++) op(1'b0, 1'b1, {bcd(d), 8'h03});
    set_sel = 1'b1;
    op(1'b0, 1'b1, {8'h30, 8'h04});

    // Apr 30 day increment wraps to 1. The simultaneous tick is dropped.
    set_sel = 1'b0;
    op(1'b1, 1'b1, {8'h01, 8'h04});

    // Walk the month to December, then the day to 31.
    set_sel = 1'b1;
    for (int m = 5; m <= 12; m++) op(1'b0, 1'b1, {8'h01, bcd(m)});
    set_sel = 1'b0;
    for (int d = 2; d <= 31; d++) op(1'b0, 1'b1, {bcd(d), 8'h12});
    set_en = 1'b0;
    op(1'b1, 1'b0, {8'h01, 8'h01});                 // Dec 31 -> Jan 1

    // A tick during CONV_MON of a prior pass gives two pulses.
    exp_q.push_back({8'h02, 8'h01});
    exp_q.push_back({8'h03, 8'h01});
    @(negedge clk); day_tick = 1'b1;                // sampled at edge k
    @(negedge clk); day_tick = 1'b0;
    @(negedge clk);                                 // CONV_DAY
    @(negedge clk);                                 // CONV_MON
    check("busy_in_conv_mon", {15'h0000, busy}, 16'h0001);
    day_tick = 1'b1;                                // sampled at edge k+3
    @(negedge clk); day_tick = 1'b0;
    repeat (10) @(negedge clk);

    // A tick while in set mode with no button press must not change the date.
    set_en = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    set_en = 1'b0;
    check("dd_out_holds_month", {11'h000, dd_out}, 16'h0001);
    check("busy_idle_end", {15'h0000, busy}, 16'h0000);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
